bus_initiator: RTL
==================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 255, stall cycles tolerated before timeout (used only with STALL_TIMEOUT_EN).
REQ-002 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have req_valid_i  input  1  requester has a transaction.
REQ-005 SHALL have req_ready_o  output  1  transaction accepted when req_valid_i && req_ready_o at the clock edge.
REQ-006 SHALL have req_write_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have req_addr_i  input  32  target byte address.
REQ-008 SHALL have req_size_i / req_mode_i  input  2 / 2  access size and privilege mode, passed through.
REQ-009 SHALL have req_wdata_i  input  32  write data.
REQ-010 SHALL have rsp_valid_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have rsp_rdata_o  output  32  read data, valid with rsp_valid_o.
REQ-012 SHALL have rsp_abort_o  output  3  abort code, valid with rsp_valid_o; 0 = success.
REQ-013 SHALL have cs_o, read_o, write_o  output  1 each  peripheral select and direction strobes.
REQ-014 SHALL have address_o  output  32, mode_o  output  2, size_o  output  2, data_o  output  32 (to target data_in).
REQ-015 SHALL have stall_i  input  1, abort_v_i  input  3, data_i  input  32 (target registered read data).

Function
REQ-016 SHALL implement states IDLE, ACCESS, RDATA; req_ready_o = 1 only in IDLE.
REQ-017 IDLE + handshake SHALL latch write, addr, size, mode, wdata and enter ACCESS next cycle.
REQ-018 In ACCESS SHALL drive cs_o = 1, read_o = !write, write_o = write, latched address/mode/size/data; all held stable until ACCESS exits.
REQ-019 read_o, write_o SHALL never be 1 while cs_o = 0; outside ACCESS cs_o, read_o, write_o = 0.
REQ-020 ACCESS with stall_i = 1 SHALL remain in ACCESS (transaction repeated unchanged).
REQ-021 ACCESS with stall_i = 0 and abort_v_i != 0 SHALL go IDLE and pulse rsp_valid_o next cycle with rsp_abort_o = abort_v_i, rsp_rdata_o = 0.
REQ-022 ACCESS, stall_i = 0, abort_v_i = 0, write SHALL go IDLE and pulse rsp_valid_o next cycle, rsp_abort_o = 0.
REQ-023 ACCESS, stall_i = 0, abort_v_i = 0, read SHALL go RDATA; in RDATA capture data_i into rsp_rdata_o, go IDLE, pulse rsp_valid_o next cycle.
REQ-024 Latency, no stall: write response 2 cycles after handshake edge, read response 3 cycles.
REQ-025 rsp_valid_o SHALL be a registered single-cycle pulse; rsp_rdata_o/rsp_abort_o hold last values until next response.
REQ-026 New request SHALL be acceptable in the same cycle rsp_valid_o is high (back-to-back).
REQ-027 req_valid_i outside IDLE SHALL be ignored, no state change.

Reset
REQ-028 Reset SHALL force IDLE, req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_abort_o = 0, cs_o/read_o/write_o = 0, address_o/data_o = 0, mode_o/size_o = 0, stall counter = 0.
REQ-029 Reset mid-transaction SHALL abandon it immediately with no response pulse.

Configuration
REQ-030 With STALL_TIMEOUT_EN defined SHALL count consecutive stalled ACCESS cycles; on reaching STALL_LIMIT SHALL exit to IDLE and pulse rsp_valid_o with rsp_abort_o = 3'b111, rsp_rdata_o = 0; counter cleared on ACCESS entry.
REQ-031 Without STALL_TIMEOUT_EN SHALL wait indefinitely on stall; no counter logic present.

Verification
REQ-032 Write addr 0x0000_0004, data 0x1234_5678, stall 0 -> one ACCESS cycle, cs_o=write_o=1, address_o/data_o as given; rsp_valid_o 2 cycles after handshake, abort 0.
REQ-033 Read addr 0x0000_000C, target data_i = 0xDEAD_BEEF in RDATA -> rsp_rdata_o = 0xDEAD_BEEF, rsp_valid_o 3 cycles after handshake.
REQ-034 Read with stall_i high 4 cycles -> ACCESS lasts 5 cycles, outputs stable; response 7 cycles after handshake.
REQ-035 Write with abort_v_i = 3'b010 -> rsp_abort_o = 3'b010, rsp_rdata_o = 0, no RDATA state.
REQ-036 STALL_TIMEOUT_EN, STALL_LIMIT = 8, stall_i held high -> cs_o drops after 8 ACCESS cycles, rsp_abort_o = 3'b111.
REQ-037 reset asserted during stalled ACCESS -> cs_o = 0 immediately, no rsp_valid_o, req_ready_o = 1.

Source files
------------

// File: rtl/bus_initiator.sv
// bus_initiator: converts a valid/ready request into a single peripheral
// access (cs/read/write strobes), waits out target stalls, collects read
// data one cycle after the access, and returns a one-cycle response pulse.
//
// Parameters:
//   STALL_LIMIT  stalled ACCESS cycles tolerated before a timeout abort
//                (only meaningful when STALL_TIMEOUT_EN is defined; >= 1)
// Build option:
//   `define STALL_TIMEOUT_EN  enables the stall timeout counter; when it is
//                             not defined the initiator waits forever on stall
// Ports:
//   clk, reset                      clock, async active-high reset
//   req_valid_i / req_ready_o       request handshake (ready only in IDLE)
//   req_write_i, req_addr_i,
//   req_size_i, req_mode_i,
//   req_wdata_i                     request payload, latched at handshake
//   rsp_valid_o, rsp_rdata_o,
//   rsp_abort_o                     registered response (abort 0 = success)
//   cs_o, read_o, write_o           peripheral select and direction strobes
//   address_o, mode_o, size_o,
//   data_o                          latched access attributes / write data
//   stall_i, abort_v_i, data_i      target stall, abort code, read data
module bus_initiator #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic [1:0]  req_mode_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [2:0]  rsp_abort_o,
  output logic        cs_o,
  output logic        read_o,
  output logic        write_o,
  output logic [31:0] address_o,
  output logic [1:0]  mode_o,
  output logic [1:0]  size_o,
  output logic [31:0] data_o,
  input  logic        stall_i,
  input  logic [2:0]  abort_v_i,
  input  logic [31:0] data_i
);

  localparam int unsigned AddrW  = 32;
  localparam int unsigned DataW  = 32;
  localparam int unsigned AbortW = 3;

  // A zero limit would time out before the first access could complete.
  if (STALL_LIMIT == 0) begin : g_limit_chk
    $error("bus_initiator: STALL_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                wr_lat_q, wr_lat_d;
  logic [AddrW-1:0]    addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          mode_q, mode_d;
  logic [DataW-1:0]    wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                cs_q, cs_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DataW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [AbortW-1:0]   rsp_abort_q, rsp_abort_d;

`ifdef STALL_TIMEOUT_EN
  // Counter only needs to reach STALL_LIMIT-1; the limit itself triggers exit.
  localparam int unsigned CntW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT);
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
`endif

  // Next-state, payload latch and response generation.
  always_comb begin
    state_d     = state_q;
    wr_lat_d    = wr_lat_q;
    addr_d      = addr_q;
    size_d      = size_q;
    mode_d      = mode_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_abort_d = rsp_abort_q;
`ifdef STALL_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d  = ACCESS;
          wr_lat_d = req_write_i;
          addr_d   = req_addr_i;
          size_d   = req_size_i;
          mode_d   = req_mode_i;
          wdata_d  = req_wdata_i;
`ifdef STALL_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
        end
      end
      ACCESS: begin
        if (stall_i) begin
`ifdef STALL_TIMEOUT_EN
          if (stall_cnt_q == CntW'(STALL_LIMIT - 1)) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_abort_d = 3'b111;
            rsp_rdata_d = '0;
          end else begin
            stall_cnt_d = stall_cnt_q + CntW'(1);
          end
`endif
        end else if (abort_v_i != '0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_abort_d = abort_v_i;
          rsp_rdata_d = '0;
        end else if (wr_lat_q) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_abort_d = '0;
          rsp_rdata_d = '0;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        // Target presents registered read data in the cycle after the access.
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_abort_d = '0;
        rsp_rdata_d = data_i;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered copies of the upcoming state so they are glitch-free.
    ready_d = (state_d == IDLE);
    cs_d    = (state_d == ACCESS);
    rd_d    = cs_d && !wr_lat_d;
    wr_d    = cs_d && wr_lat_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_lat_q    <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      mode_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_abort_q <= '0;
`ifdef STALL_TIMEOUT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_lat_q    <= wr_lat_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      mode_q      <= mode_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_abort_q <= rsp_abort_d;
`ifdef STALL_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign req_ready_o = ready_q;
  assign cs_o        = cs_q;
  assign read_o      = rd_q;
  assign write_o     = wr_q;
  assign address_o   = addr_q;
  assign mode_o      = mode_q;
  assign size_o      = size_q;
  assign data_o      = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_abort_o = rsp_abort_q;

endmodule
